// File: rtl/sprite_pixel_arbiter_if.sv
// Sprite request bus: one request pulse, RAM address and layer per sprite engine.
// The sprite engines drive it through the master modport; the arbiter reads it
// through the slave modport.
interface sprite_pixel_arbiter_if #(
    parameter int N_SPRITES     = 4,
    parameter int RAM_ADD_WIDTH = 16
);
    logic [N_SPRITES-1:0]               req;
    logic [N_SPRITES*RAM_ADD_WIDTH-1:0] req_addr;
    logic [N_SPRITES*2-1:0]             req_layer;

    modport master (output req, output req_addr, output req_layer);
    modport slave  (input  req, input  req_addr, input  req_layer);
endinterface

// File: rtl/sprite_pixel_arbiter.sv
// Sprite pixel arbiter: collects one-cycle sprite requests in the capture slot
// that follows each clk25en, picks the topmost layer (lowest index on ties),
// reads that sprite's pixel from block RAM and emits one colour per pixel period.
// Pipeline: capture (C) -> select/RAM addr (C+1) -> RAM read (C+2) -> colour (C+3),
// with pixel_valid high during C+4.
module sprite_pixel_arbiter #(
    parameter int                     N_SPRITES     = 4,
    parameter int                     RAM_ADD_WIDTH = 16,
    parameter int                     COLOR_WIDTH   = 12,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk25en,
    input  logic                     blank,
    sprite_pixel_arbiter_if.slave    req_bus,
    input  logic [COLOR_WIDTH-1:0]   bg_color,
    output logic [RAM_ADD_WIDTH-1:0] ram_addr,
    output logic                     ram_en,
    input  logic [COLOR_WIDTH-1:0]   ram_dout,
    output logic [COLOR_WIDTH-1:0]   pixel_out,
    output logic                     pixel_valid,
    output logic                     req_err
);
    localparam int STAGES = 4;

    // Capture-slot marker: high in the cycle after clk25en.
    logic                                        en_q;
    // Per-stage valid bits: [1] stage 2 active, [2] RAM read, [3] colour pick,
    // [4] pixel_valid.
    logic [STAGES:1]                             vld_pipe_q;

    // Stage 1 capture registers.
    logic [N_SPRITES-1:0]                        cap_req_q;
    logic [N_SPRITES-1:0][RAM_ADD_WIDTH-1:0]     cap_addr_q;
    logic [N_SPRITES-1:0][1:0]                   cap_layer_q;
    logic                                        cap_blank_q;

    // Stage 2 / 3 side-band bits travelling with the RAM access.
    logic                                        hit2_q, hit3_q;
    logic                                        blank2_q, blank3_q;

    logic [RAM_ADD_WIDTH-1:0]                    ram_addr_q;
    logic                                        ram_en_q, ram_en_d;
    logic [COLOR_WIDTH-1:0]                      pixel_q, pixel_d;
    logic                                        req_err_q, req_err_d;

    // Winner selection results (combinational from the capture registers).
    logic                                        hit_d;
    logic [1:0]                                  best_layer_d;
    logic [RAM_ADD_WIDTH-1:0]                    win_addr_d;

    // Register clk25en to locate the capture slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= clk25en;
    end

    // Valid shift register: every capture slot launches exactly one pixel,
    // requests or not, so throughput is one output per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], en_q};
    end

    // Stage 1: latch requests, addresses, layers and blank in the capture slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_req_q   <= '0;
            cap_addr_q  <= '0;
            cap_layer_q <= '0;
            cap_blank_q <= 1'b0;
        end else if (en_q) begin
            cap_req_q   <= req_bus.req;
            cap_addr_q  <= req_bus.req_addr;
            cap_layer_q <= req_bus.req_layer;
            cap_blank_q <= blank;
        end
    end

    // Pick the highest-layer requester; strict '>' keeps the lowest index on ties.
    always_comb begin
        hit_d        = 1'b0;
        best_layer_d = '0;
        win_addr_d   = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (cap_req_q[i] && (!hit_d || (cap_layer_q[i] > best_layer_d))) begin
                hit_d        = 1'b1;
                best_layer_d = cap_layer_q[i];
                win_addr_d   = cap_addr_q[i];
            end
        end
    end

    assign ram_en_d = vld_pipe_q[1] & hit_d;

    // Stage 2: issue the RAM read for the winner; ram_en lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
            ram_en_q   <= 1'b0;
            hit2_q     <= 1'b0;
            blank2_q   <= 1'b0;
        end else begin
            ram_en_q <= ram_en_d;
            if (ram_en_d) ram_addr_q <= win_addr_d;
            if (vld_pipe_q[1]) begin
                hit2_q   <= hit_d;
                blank2_q <= cap_blank_q;
            end
        end
    end

    // Stage 3: carry hit/blank while the RAM produces its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit3_q   <= 1'b0;
            blank3_q <= 1'b0;
        end else if (vld_pipe_q[2]) begin
            hit3_q   <= hit2_q;
            blank3_q <= blank2_q;
        end
    end

    // Colour priority: blanking, then no winner, then transparent texel, then texel.
    always_comb begin
        pixel_d = ram_dout;
        if (blank3_q)                    pixel_d = '0;
        else if (!hit3_q)                pixel_d = bg_color;
        else if (ram_dout == TRANSPARENT) pixel_d = bg_color;
    end

    // Stage 4: update the held output colour once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             pixel_q <= '0;
        else if (vld_pipe_q[3]) pixel_q <= pixel_d;
    end

    // Any request outside the capture slot is ignored but flagged until reset.
    assign req_err_d = req_err_q | (~en_q & (|req_bus.req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_err_q <= 1'b0;
        else        req_err_q <= req_err_d;
    end

    assign ram_addr    = ram_addr_q;
    assign ram_en      = ram_en_q;
    assign pixel_out   = pixel_q;
    assign pixel_valid = vld_pipe_q[STAGES];
    assign req_err     = req_err_q;
endmodule

// File: tb/tb_sprite_pixel_arbiter.sv
// Directed bench for sprite_pixel_arbiter: each call to run_slot drives one
// pixel period (E: clk25en, C: capture, C+1, C+2). The pixel of a slot shows
// up in the C cycle of the following run_slot call.
module tb_sprite_pixel_arbiter;
    logic        clk;
    logic        rst_n;
    logic        clk25en;
    logic        blank;
    logic [11:0] bg_color;
    logic [15:0] ram_addr;
    logic        ram_en;
    logic [11:0] ram_dout;
    logic [11:0] pixel_out;
    logic        pixel_valid;
    logic        req_err;

    int n_cmp;
    int n_err;

    sprite_pixel_arbiter_if #(.N_SPRITES(4), .RAM_ADD_WIDTH(16)) rbus();

    sprite_pixel_arbiter #(
        .N_SPRITES(4), .RAM_ADD_WIDTH(16), .COLOR_WIDTH(12), .TRANSPARENT(12'h000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk25en(clk25en), .blank(blank),
        .req_bus(rbus), .bg_color(bg_color),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_dout(ram_dout),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .req_err(req_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous block-RAM model: data one clock after ram_en.
    logic [11:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    // Observations captured by run_slot.
    int          s_en_cnt, s_pv_cnt;
    logic        s_pv_c, s_en_c2, s_err_c2;
    logic [11:0] s_pix_c, s_hold_c2;
    logic [15:0] s_addr_c2;

    task automatic run_slot(input logic [3:0] r, input logic [63:0] a,
                            input logic [7:0] l, input logic bl, input logic late);
        s_en_cnt = 0;
        s_pv_cnt = 0;
        @(posedge clk); #1;                       // E
        clk25en = 1'b1; rbus.req = '0; blank = bl;
        if (ram_en) s_en_cnt++;
        if (pixel_valid) s_pv_cnt++;
        @(posedge clk); #1;                       // C
        clk25en = 1'b0; rbus.req = late ? 4'b0 : r;
        rbus.req_addr = a; rbus.req_layer = l;
        if (ram_en) s_en_cnt++;
        if (pixel_valid) s_pv_cnt++;
        s_pv_c = pixel_valid; s_pix_c = pixel_out;
        @(posedge clk); #1;                       // C+1
        rbus.req = late ? r : 4'b0;
        if (ram_en) s_en_cnt++;
        if (pixel_valid) s_pv_cnt++;
        @(posedge clk); #1;                       // C+2
        rbus.req = '0;
        if (ram_en) s_en_cnt++;
        if (pixel_valid) s_pv_cnt++;
        s_en_c2 = ram_en; s_addr_c2 = ram_addr; s_err_c2 = req_err; s_hold_c2 = pixel_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk25en = 1'b0; blank = 1'b0; bg_color = 12'h00F;
        rbus.req = '0; rbus.req_addr = '0; rbus.req_layer = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ram_addr, ram_en, pixel_out, pixel_valid, req_err} !== 31'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%h en=%b pix=%h pv=%b err=%b, want all 0",
                     ram_addr, ram_en, pixel_out, pixel_valid, req_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bg_color = 12'h00F;
        run_slot(4'b0001, {48'h0, 16'h0100}, 8'b00_00_00_01, 1'b0, 1'b0);
        n_cmp++;
        if (s_en_c2 !== 1'b1 || s_addr_c2 !== 16'h0100 || s_en_cnt != 1) begin
            n_err++;
            $display("FAIL single_ram: got en@C+2=%b addr=%h pulses=%0d, want 1 0100 1",
                     s_en_c2, s_addr_c2, s_en_cnt);
        end
        n_cmp++;
        if (s_pv_cnt != 0) begin
            n_err++;
            $display("FAIL single_first_slot_pv: got %0d pulses, want 0", s_pv_cnt);
        end
        run_slot(4'b0000, 64'h0, 8'h0, 1'b0, 1'b0);
        n_cmp++;
        if (s_pv_c !== 1'b1 || s_pix_c !== 12'hF00) begin
            n_err++;
            $display("FAIL single_pixel: got pv=%b pix=%h, want 1 F00", s_pv_c, s_pix_c);
        end
        n_cmp++;
        if (s_hold_c2 !== 12'hF00 || s_pv_cnt != 1) begin
            n_err++;
            $display("FAIL single_hold: got pix@C+2=%h pv pulses=%0d, want F00 1", s_hold_c2, s_pv_cnt);
        end
    endtask

    task automatic test_layer_priority();
        run_slot(4'b0101, {16'h0, 16'h0020, 16'h0, 16'h0010}, 8'b00_11_00_01, 1'b0, 1'b0);
        n_cmp++;
        if (s_en_c2 !== 1'b1 || s_addr_c2 !== 16'h0020) begin
            n_err++;
            $display("FAIL layer_top_addr: got en=%b addr=%h, want 1 0020", s_en_c2, s_addr_c2);
        end
        run_slot(4'b1010, {16'h0040, 16'h0, 16'h0030, 16'h0}, 8'b10_00_10_00, 1'b0, 1'b0);
        n_cmp++;
        if (s_pix_c !== 12'h0F0) begin
            n_err++;
            $display("FAIL layer_top_pixel: got %h, want 0F0", s_pix_c);
        end
        n_cmp++;
        if (s_addr_c2 !== 16'h0030) begin
            n_err++;
            $display("FAIL layer_tie_addr: got %h, want 0030", s_addr_c2);
        end
        run_slot(4'b0000, 64'h0, 8'h0, 1'b0, 1'b0);
        n_cmp++;
        if (s_pix_c !== 12'h333) begin
            n_err++;
            $display("FAIL layer_tie_pixel: got %h, want 333", s_pix_c);
        end
    endtask

    task automatic test_no_request();
        bg_color = 12'h00F;
        for (int k = 0; k < 3; k++) begin
            run_slot(4'b0000, 64'h0, 8'h0, 1'b0, 1'b0);
            n_cmp++;
            if (s_en_cnt != 0 || s_pv_cnt != 1 || s_pix_c !== 12'h00F) begin
                n_err++;
                $display("FAIL no_request[%0d]: got en pulses=%0d pv pulses=%0d pix=%h, want 0 1 00F",
                         k, s_en_cnt, s_pv_cnt, s_pix_c);
            end
        end
    endtask

    task automatic test_transparency_blank();
        bg_color = 12'h0A0;
        run_slot(4'b0001, {48'h0, 16'h0050}, 8'b00_00_00_00, 1'b0, 1'b0);
        run_slot(4'b0001, {48'h0, 16'h0100}, 8'b00_00_00_10, 1'b1, 1'b0);
        n_cmp++;
        if (s_pix_c !== 12'h0A0) begin
            n_err++;
            $display("FAIL transparent_bg: got %h, want 0A0", s_pix_c);
        end
        n_cmp++;
        if (s_en_c2 !== 1'b1) begin
            n_err++;
            $display("FAIL blank_ram_en: got %b, want 1", s_en_c2);
        end
        run_slot(4'b0000, 64'h0, 8'h0, 1'b0, 1'b0);
        n_cmp++;
        if (s_pv_c !== 1'b1 || s_pix_c !== 12'h000) begin
            n_err++;
            $display("FAIL blank_pixel: got pv=%b pix=%h, want 1 000", s_pv_c, s_pix_c);
        end
    endtask

    task automatic test_protocol_error();
        n_cmp++;
        if (req_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear_before: got %b, want 0", req_err);
        end
        run_slot(4'b0010, {32'h0, 16'h0030, 16'h0}, 8'b00_00_11_00, 1'b0, 1'b1);
        n_cmp++;
        if (s_err_c2 !== 1'b1 || s_en_cnt != 0) begin
            n_err++;
            $display("FAIL err_late_req: got err=%b en pulses=%0d, want 1 0", s_err_c2, s_en_cnt);
        end
        run_slot(4'b0001, {48'h0, 16'h0100}, 8'b00_00_00_01, 1'b0, 1'b0);
        n_cmp++;
        if (s_pix_c !== 12'h0A0 || s_err_c2 !== 1'b1) begin
            n_err++;
            $display("FAIL err_ignored_sticky: got pix=%h err=%b, want 0A0 1", s_pix_c, s_err_c2);
        end
        n_cmp++;
        if (s_en_c2 !== 1'b1 || s_addr_c2 !== 16'h0100) begin
            n_err++;
            $display("FAIL err_next_slot_ram: got en=%b addr=%h, want 1 0100", s_en_c2, s_addr_c2);
        end
        run_slot(4'b0000, 64'h0, 8'h0, 1'b0, 1'b0);
        n_cmp++;
        if (s_pix_c !== 12'hF00) begin
            n_err++;
            $display("FAIL err_next_slot_pixel: got %h, want F00", s_pix_c);
        end
    endtask

    task automatic test_reset_mid();
        int pv_seen;
        @(posedge clk); #1;                       // E
        clk25en = 1'b1;
        @(posedge clk); #1;                       // C
        clk25en = 1'b0; rbus.req = 4'b0001;
        rbus.req_addr = {48'h0, 16'h0020}; rbus.req_layer = 8'b00_00_00_01;
        @(posedge clk); #1;                       // C+1
        rbus.req = '0;
        @(posedge clk); #1;                       // C+2
        n_cmp++;
        if (ram_en !== 1'b1 || ram_addr !== 16'h0020) begin
            n_err++;
            $display("FAIL rstmid_inflight: got en=%b addr=%h, want 1 0020", ram_en, ram_addr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ram_addr, ram_en, pixel_out, pixel_valid, req_err} !== 31'd0) begin
            n_err++;
            $display("FAIL rstmid_async: got addr=%h en=%b pix=%h pv=%b err=%b, want all 0",
                     ram_addr, ram_en, pixel_out, pixel_valid, req_err);
        end
        pv_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (pixel_valid) pv_seen++;
        end
        rst_n = 1'b1;
        run_slot(4'b0001, {48'h0, 16'h0040}, 8'b00_00_00_00, 1'b0, 1'b0);
        n_cmp++;
        if (pv_seen != 0 || s_pv_cnt != 0) begin
            n_err++;
            $display("FAIL rstmid_no_partial: got pv pulses %0d+%0d, want 0", pv_seen, s_pv_cnt);
        end
        n_cmp++;
        if (s_en_c2 !== 1'b1 || s_addr_c2 !== 16'h0040) begin
            n_err++;
            $display("FAIL rstmid_first_ram: got en=%b addr=%h, want 1 0040", s_en_c2, s_addr_c2);
        end
        run_slot(4'b0000, 64'h0, 8'h0, 1'b0, 1'b0);
        n_cmp++;
        if (s_pv_c !== 1'b1 || s_pix_c !== 12'h444) begin
            n_err++;
            $display("FAIL rstmid_first_pixel: got pv=%b pix=%h, want 1 444", s_pv_c, s_pix_c);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ram_dout = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 12'h5A5;
        mem[16'h0100] = 12'hF00;
        mem[16'h0010] = 12'h111;
        mem[16'h0020] = 12'h0F0;
        mem[16'h0030] = 12'h333;
        mem[16'h0040] = 12'h444;
        mem[16'h0050] = 12'h000;

        test_reset();
        test_single();
        test_layer_priority();
        test_no_request();
        test_transparency_blank();
        test_protocol_error();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
